// File: rtl/noise_request_scheduler.sv
// Round-robin scheduler sharing one LFSR noise source among voice requesters.
// Define NOISE_SCHED_ABORT_CNT_EN to add the saturating abort_count output.
module noise_request_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int SAMPLE_W = 8,
  parameter int DIV_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  input  logic [DIV_W-1:0]    div,
  input  logic                reseed_req,
  input  logic                noise_bit,
  output logic                noise_en,
  output logic                noise_reseed,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ack
`ifdef NOISE_SCHED_ABORT_CNT_EN
  ,
  output logic [7:0]          abort_count
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(SAMPLE_W + 1);

  typedef enum logic [2:0] {
    IDLE, ARB, COLLECT, DELIVER, RESEED
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]    ptr, win, pick, ptr_n;
  logic             found;
  logic [DIV_W-1:0] div_q, div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             rs_cnt;
  logic             pending;
  logic             held;
  logic             strobe;
  logic             abort;
  logic             last_bit;

  assign held     = req[win];
  assign strobe   = (state == COLLECT) && held && (div_cnt == div_q);
  assign abort    = ((state == COLLECT) || (state == DELIVER)) && !held;
  assign last_bit = (bit_cnt == BW'(SAMPLE_W - 1));

  assign noise_en     = strobe;
  assign noise_reseed = (state == RESEED);
  assign sample_valid = (state == DELIVER);

  // first requester at or after the pointer, wrapping
  always_comb begin
    int idx;
    int nxt;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    nxt   = (int'(pick) + 1) % NUM_REQ;
    ptr_n = PW'(nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (pending || reseed_req) state_n = RESEED;
        else if (|req)             state_n = ARB;
      end
      ARB:     state_n = found ? COLLECT : IDLE;
      COLLECT: begin
        if (!held)                     state_n = IDLE;
        else if (strobe && last_bit)   state_n = DELIVER;
      end
      DELIVER: if (!held || sample_ack) state_n = IDLE;
      RESEED:  if (rs_cnt)              state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt     <= '0;
      ptr     <= '0;
      win     <= '0;
      div_q   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sample  <= '0;
      rs_cnt  <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (state == ARB) begin
        div_q   <= div;
        div_cnt <= '0;
        bit_cnt <= '0;
        if (found) begin
          win <= pick;
          ptr <= ptr_n;
        end
      end else if (strobe) begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + 1'b1;
        sample  <= {sample[SAMPLE_W-2:0], noise_bit};
      end else if (state == COLLECT) begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state == ARB && found)
        gnt <= NUM_REQ'(1) << pick;
      else if (state_n != COLLECT && state_n != DELIVER)
        gnt <= '0;

      rs_cnt <= (state == RESEED) ? ~rs_cnt : 1'b0;

      // pulses during RESEED are absorbed by the reseed in progress
      if (state == IDLE && state_n == RESEED)
        pending <= 1'b0;
      else if (reseed_req && state != IDLE && state != RESEED)
        pending <= 1'b1;
    end
  end

`ifdef NOISE_SCHED_ABORT_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      abort_count <= '0;
    else if (abort && abort_count != 8'hFF)
      abort_count <= abort_count + 1'b1;
  end
`endif

endmodule
